// File: rtl/percep_ld_if.sv
// percep_ld_if: host-word handshake plus FSM pop/data bus of the perceptron loader
interface percep_ld_if #(
  parameter int FP_WIDTH      = 16,
  parameter int MEM_WIDTH_YDX = 17
);
  logic                     in_valid;
  logic                     in_ready;
  logic [FP_WIDTH-1:0]      in_data;
  logic                     in_yd;
  logic                     pop;
  logic [MEM_WIDTH_YDX-1:0] ld_data;
  logic                     infer_ena;
  logic                     ld_done;
  logic                     ld_err;
  modport master (
    output in_valid, in_data, in_yd, pop,
    input  in_ready, ld_data, infer_ena, ld_done, ld_err
  );
  modport slave (
    input  in_valid, in_data, in_yd, pop,
    output in_ready, ld_data, infer_ena, ld_done, ld_err
  );
endinterface

// File: rtl/percep_ld_buf.sv
// percep_ld_buf: buffers the inference set and w0~w4 from the host, then streams them to the perceptron FSM.
// Define PERCEP_LD_CHK_EN to require a trailing XOR checksum word before arming.
module percep_ld_buf #(
  parameter int MEM_WIDTH_YDX = 17,
  parameter int FP_WIDTH      = 16,
  parameter int INFER_NUM     = 20,
  parameter int ATTR          = 5,
  parameter int TOTAL         = INFER_NUM*ATTR+ATTR,
  parameter int PTR_W         = 7
) (
  input logic        clk,
  input logic        rst_n,
  percep_ld_if.slave bus
);
  localparam int NX = INFER_NUM*ATTR;
`ifdef PERCEP_LD_CHK_EN
  localparam int NIN = TOTAL+1;
  typedef enum logic [2:0] {FILL, ARM, DRAIN, DONE, ERR} state_t;
`else
  localparam int NIN = TOTAL;
  typedef enum logic [1:0] {FILL, ARM, DRAIN, DONE} state_t;
`endif
  state_t state, state_nx;
  logic [MEM_WIDTH_YDX-1:0] mem [TOTAL];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic err_q, err_set, xfer, last_in, empty, drain_pop;
  assign xfer      = bus.in_valid & bus.in_ready;
  assign last_in   = wr_ptr == PTR_W'(NIN-1);
  assign empty     = rd_ptr >= wr_ptr || rd_ptr >= PTR_W'(TOTAL);
  assign drain_pop = state == DRAIN && bus.pop && !empty;
`ifdef PERCEP_LD_CHK_EN
  logic [FP_WIDTH-1:0] chk;
  logic chk_ok;
  assign chk_ok = bus.in_data == chk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chk <= '0;
    else if (xfer && !last_in) chk <= chk ^ bus.in_data;
`endif
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      FILL: begin
        err_set = bus.pop;
`ifdef PERCEP_LD_CHK_EN
        if (xfer && last_in) state_nx = chk_ok ? ARM : ERR;
        if (xfer && last_in && !chk_ok) err_set = 1'b1;
`else
        if (xfer && last_in) state_nx = ARM;
`endif
      end
      ARM: begin
        state_nx = DRAIN;
        err_set  = bus.pop;
      end
      DRAIN: begin
        err_set = bus.pop && empty;
        if (drain_pop && rd_ptr == PTR_W'(TOTAL-1)) state_nx = DONE;
      end
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) wr_ptr <= wr_ptr + 1'b1;
      if (drain_pop) rd_ptr <= rd_ptr + 1'b1;
      if (err_set) err_q <= 1'b1;
    end
  // label bit only travels with x words; weights land with a zero top bit
  always_ff @(posedge clk)
    if (xfer && wr_ptr < PTR_W'(TOTAL))
      mem[wr_ptr] <= MEM_WIDTH_YDX'({wr_ptr < PTR_W'(NX) ? bus.in_yd : 1'b0, bus.in_data});
  assign bus.in_ready  = rst_n && state == FILL;
  assign bus.infer_ena = state == ARM;
  assign bus.ld_done   = state == DONE;
  assign bus.ld_err    = err_q;
  assign bus.ld_data   = (state == DRAIN && !empty) ? mem[rd_ptr] : '0;
endmodule
